// File: rtl/scale_loop_controller.sv
// Per-frame scale loop: fetch scale params, gate on window size, launch detector.
// Ports: clk/resetn, frame_start/win_size in, sp_* generator handshake, det_* detector, busy/frame_done/scale_index.
module scale_loop_controller #(
  parameter int ROWBITS   = 10,
  parameter int COLBITS   = 10,
  parameter int WINBITS   = 12,
  parameter int MAXSCALES = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               frame_start,
  input  logic [WINBITS-1:0] win_size,
  output logic               busy,
  output logic               frame_done,
  output logic               sp_start,
  input  logic               sp_ready,
  input  logic               sp_done,
  output logic               sp_taken,
  input  logic [ROWBITS-1:0] sp_scale_w,
  input  logic [COLBITS-1:0] sp_scale_h,
  output logic               det_start,
  output logic [ROWBITS-1:0] det_width,
  output logic [COLBITS-1:0] det_height,
  input  logic               det_done,
  output logic [7:0]         scale_index
);

  localparam int RC = (ROWBITS > COLBITS) ? ROWBITS : COLBITS;
  localparam int MW = (RC > WINBITS) ? RC : WINBITS;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_PARAM, CHECK, DETECT, WAIT_DET, FINISH
  } state_t;

  state_t             state;
  logic [WINBITS-1:0] win_q;
  logic [MW-1:0]      w_ext;
  logic [MW-1:0]      h_ext;
  logic [MW-1:0]      win_ext;
  logic               too_small;
  logic               at_max;

  // Zero-extend everything to a common width before comparing.
  assign w_ext     = MW'(det_width);
  assign h_ext     = MW'(det_height);
  assign win_ext   = MW'(win_q);
  assign too_small = (w_ext < win_ext) || (h_ext < win_ext);
  assign at_max    = (scale_index == 8'(MAXSCALES));

  assign busy       = (state != IDLE);
  assign sp_start   = (state == ISSUE);
  assign sp_taken   = (state == WAIT_PARAM) && sp_done;
  assign det_start  = (state == DETECT);
  assign frame_done = (state == FINISH);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      win_q       <= '0;
      det_width   <= '0;
      det_height  <= '0;
      scale_index <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (frame_start) begin
            win_q       <= win_size;
            scale_index <= '0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (sp_ready) state <= WAIT_PARAM;
        end
        WAIT_PARAM: begin
          if (sp_done) begin
            det_width  <= sp_scale_w;
            det_height <= sp_scale_h;
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (too_small || at_max) state <= FINISH;
          else                     state <= DETECT;
        end
        DETECT: state <= WAIT_DET;
        WAIT_DET: begin
          if (det_done) begin
            if (scale_index != 8'hFF)
              scale_index <= scale_index + 8'd1;
            state <= ISSUE;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/scale_loop_controller.md
SCALE_LOOP_CONTROLLER -- requirements
Module: scale_loop_controller

Interface
REQ-001 SHALL have parameter ROWBITS, default 10, scaled/base image width bits.
REQ-002 SHALL have parameter COLBITS, default 10, scaled/base image height bits.
REQ-003 SHALL have parameter WINBITS, default 12, window size bits.
REQ-004 SHALL have parameter MAXSCALES, default 32, maximum scales per frame, 1..255.
REQ-005 SHALL have ports, one per line (name, direction, width, meaning):
 clk  in  1  clock.
 resetn  in  1  reset: synchronous, active-low.
 frame_start  in  1  frame request; accepted only in IDLE.
 win_size  in  WINBITS  detection window size; latched with frame_start.
 busy  out  1  high in every state except IDLE.
 frame_done  out  1  one-cycle end-of-frame pulse.
 sp_start  out  1  start request to the scale-parameter generator.
 sp_ready  in  1  generator ready.
 sp_done  in  1  generator result valid.
 sp_taken  out  1  result consumed.
 sp_scale_w  in  ROWBITS  scaled width from generator.
 sp_scale_h  in  COLBITS  scaled height from generator.
 det_start  out  1  one-cycle detector launch pulse.
 det_width  out  ROWBITS  latched scaled width for the detector.
 det_height  out  COLBITS  latched scaled height for the detector.
 det_done  in  1  detector finished current scale.
 scale_index  out  8  count of scales processed this frame.

Function
REQ-006 SHALL implement states IDLE, ISSUE, WAIT_PARAM, CHECK, DETECT, WAIT_DET, FINISH, registered and updated on the rising edge of clk.
REQ-007 IDLE: frame_start=1 SHALL latch win_size, clear scale_index and move to ISSUE; otherwise stay in IDLE.
REQ-008 ISSUE: sp_start SHALL be 1 combinationally; sp_ready=1 SHALL move to WAIT_PARAM, else stay in ISSUE with sp_start held high.
REQ-009 WAIT_PARAM: sp_done=1 SHALL drive sp_taken=1 combinationally in that same cycle, latch sp_scale_w/sp_scale_h into det_width/det_height, and move to CHECK.
REQ-010 sp_taken SHALL be 0 in all other cycles; sp_start SHALL be 0 outside ISSUE.
REQ-011 CHECK: move to FINISH if det_width<win_size, or det_height<win_size, or scale_index==MAXSCALES; otherwise move to DETECT.
REQ-012 The comparisons in REQ-011 SHALL be unsigned, with operands zero-extended to max(ROWBITS,COLBITS,WINBITS).
REQ-013 DETECT: det_start SHALL be 1 for exactly this one cycle, then move to WAIT_DET.
REQ-014 WAIT_DET: det_done=1 SHALL increment scale_index (saturating at 255) and move to ISSUE.
REQ-015 FINISH: frame_done SHALL be 1 for exactly one cycle, then move to IDLE; scale_index SHALL hold its value until the next accepted frame_start.
REQ-016 frame_start outside IDLE, det_done outside WAIT_DET and sp_done outside WAIT_PARAM SHALL be ignored, with no state change.
REQ-017 Latency from frame_start to the first sp_start SHALL be 1 cycle; from det_done to the next sp_start, 1 cycle.
REQ-018 Latency from sp_done to det_start SHALL be 2 cycles when CHECK passes.
REQ-019 A scale-size failure at the first scale SHALL give frame_done with scale_index=0 and no det_start.

Reset
REQ-020 resetn=0 at a clock edge SHALL force IDLE, including mid-frame in any state.
REQ-021 Under reset, busy, frame_done, sp_start, sp_taken and det_start SHALL be 0.
REQ-022 Under reset, det_width, det_height, scale_index and the latched win_size SHALL be 0.
REQ-023 After resetn rises, the block SHALL accept frame_start on the first cycle.

Verification
REQ-024 win=24, MAXSCALES=32, generator returns 266x200, 222x167, 185x139, 154x116, ... shrinking by 1.2, immediate det_done -> det_start issued for each scale until width<24 or height<24; frame_done follows; scale_index equals the number of det_start pulses.
REQ-025 win=24, first result 20x200 -> no det_start; frame_done 1 cycle after CHECK; scale_index=0.
REQ-026 MAXSCALES=3, win=1, generator always returns 100x100 -> exactly 3 det_start pulses, then frame_done, scale_index=3.
REQ-027 sp_ready held low 5 cycles in ISSUE -> sp_start stays high for all 5 cycles; exactly one handshake when sp_ready rises; sp_taken pulses once per sp_done.
REQ-028 frame_start pulsed during WAIT_DET; spurious det_done in WAIT_PARAM -> both ignored, sequence unchanged.
REQ-029 resetn=0 during WAIT_DET -> next cycle IDLE with all outputs 0; a new frame then completes normally.
